sc_io_peripheral: RTL and testbench

Board-side I/O peripheral for the single-cycle computer's port interface. It produces in_port0/in_port1 from debounced slide switches. It consumes out_port0/out_port1 and shows each as a clipped 3-digit decimal number on six active-low seven-segment displays. Binary-to-BCD conversion is a sequential shift-add-3 engine that serves the two output ports round-robin.

---
 rtl/sc_io_peripheral.sv | 240 ++++++++++++++++++++++++
 tb/tb_sc_io_peripheral.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_io_peripheral.sv
// sc_io_peripheral: board-side I/O for the single-cycle computer port interface.
//   Slide switches are synchronized and debounced per bit, then presented as
//   in_port0 = {27'b0, sw[4:0]} and in_port1 = {27'b0, sw[9:5]}.
//   out_port0/out_port1 are clipped to 999, converted to BCD by a sequential
//   shift-add-3 engine (round-robin between the two ports) and shown on
//   active-low seven-segment displays with leading-zero blanking.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   sw[9:0]                 - raw asynchronous slide switches
//   out_port0/1[31:0]       - CPU output ports (port0 -> hex5..hex3, port1 -> hex2..hex0)
//   in_port0/1[31:0]        - debounced switch values, registered
//   hex0..hex5[6:0]         - segments {g,f,e,d,c,b,a}, 0 = lit
//   update, update_port     - one-cycle pulse when a digit group is written, and which group
module sc_io_peripheral #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  sw,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        update,
  output logic        update_port
);

  localparam int unsigned SW_W     = 10;
  localparam int unsigned NUM_W    = 32;
  localparam int unsigned BIN_W    = 10;
  localparam int unsigned BCD_W    = 12;
  localparam int unsigned SH_W     = BCD_W + BIN_W;
  localparam int unsigned ITER_W   = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned MAX_DISP = 999;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_CONV  = 2'd1,
    S_STORE = 2'd2
  } state_t;

  // Active-low segment pattern for one decimal digit.
  function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Switch path: 2-flop synchronizer, then an independent debouncer per bit.
  // ---------------------------------------------------------------------------
  logic [SW_W-1:0]  sync1;
  logic [SW_W-1:0]  sync2;
  logic [SW_W-1:0]  stable;
  logic [CNT_W-1:0] db_cnt [SW_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < SW_W; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      for (int i = 0; i < SW_W; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registered input ports.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_port0 <= '0;
      in_port1 <= '0;
    end else begin
      in_port0 <= {27'd0, stable[4:0]};
      in_port1 <= {27'd0, stable[9:5]};
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion engine: LOAD (1) -> CONV (10) -> STORE (1), alternating ports.
  // ---------------------------------------------------------------------------
  state_t             state;
  state_t             state_n;
  logic               sel;
  logic               sel_n;
  logic [ITER_W-1:0]  iter;
  logic [ITER_W-1:0]  iter_n;
  logic [SH_W-1:0]    sh;
  logic [SH_W-1:0]    sh_n;
  logic [SEG_W-1:0]   hex0_n, hex1_n, hex2_n, hex3_n, hex4_n, hex5_n;
  logic               update_n;
  logic               update_port_n;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_LOAD:  state_n = S_CONV;
      S_CONV:  if (iter == ITER_W'(BIN_W - 1)) state_n = S_STORE;
      S_STORE: state_n = S_LOAD;
      default: state_n = S_LOAD;
    endcase
  end

  // Datapath / output next values.
  logic [NUM_W-1:0] port_v;
  logic [BIN_W-1:0] v_clip;
  logic [SH_W-1:0]  adj;
  logic [3:0]       d_hund;
  logic [3:0]       d_tens;
  logic [3:0]       d_ones;

  always_comb begin
    sel_n         = sel;
    iter_n        = iter;
    sh_n          = sh;
    hex0_n        = hex0;
    hex1_n        = hex1;
    hex2_n        = hex2;
    hex3_n        = hex3;
    hex4_n        = hex4;
    hex5_n        = hex5;
    update_n      = 1'b0;
    update_port_n = update_port;
    adj           = sh;

    // Full 32-bit compare so large values clip instead of wrapping.
    port_v = sel ? out_port1 : out_port0;
    v_clip = (port_v > NUM_W'(MAX_DISP)) ? BIN_W'(MAX_DISP) : port_v[BIN_W-1:0];

    d_hund = sh[BIN_W+8 +: 4];
    d_tens = sh[BIN_W+4 +: 4];
    d_ones = sh[BIN_W   +: 4];

    case (state)
      S_LOAD: begin
        sh_n   = {BCD_W'(0), v_clip};
        iter_n = '0;
      end
      S_CONV: begin
        for (int d = 0; d < 3; d++) begin
          if (adj[BIN_W + 4*d +: 4] >= 4'd5) begin
            adj[BIN_W + 4*d +: 4] = adj[BIN_W + 4*d +: 4] + 4'd3;
          end
        end
        sh_n   = {adj[SH_W-2:0], 1'b0};
        iter_n = iter + ITER_W'(1);
      end
      S_STORE: begin
        update_n      = 1'b1;
        update_port_n = sel;
        sel_n         = ~sel;
        if (!sel) begin
          hex5_n = (d_hund == 4'd0) ? SEG_BLANK : seg7(d_hund);
          hex4_n = (d_hund == 4'd0 && d_tens == 4'd0) ? SEG_BLANK : seg7(d_tens);
          hex3_n = seg7(d_ones);
        end else begin
          hex2_n = (d_hund == 4'd0) ? SEG_BLANK : seg7(d_hund);
          hex1_n = (d_hund == 4'd0 && d_tens == 4'd0) ? SEG_BLANK : seg7(d_tens);
          hex0_n = seg7(d_ones);
        end
      end
      default: begin
        sh_n = sh;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel         <= 1'b0;
      iter        <= '0;
      sh          <= '0;
      hex0        <= SEG_BLANK;
      hex1        <= SEG_BLANK;
      hex2        <= SEG_BLANK;
      hex3        <= SEG_BLANK;
      hex4        <= SEG_BLANK;
      hex5        <= SEG_BLANK;
      update      <= 1'b0;
      update_port <= 1'b0;
    end else begin
      sel         <= sel_n;
      iter        <= iter_n;
      sh          <= sh_n;
      hex0        <= hex0_n;
      hex1        <= hex1_n;
      hex2        <= hex2_n;
      hex3        <= hex3_n;
      hex4        <= hex4_n;
      hex5        <= hex5_n;
      update      <= update_n;
      update_port <= update_port_n;
    end
  end

endmodule

// File: tb/tb_sc_io_peripheral.sv
// Directed bench for sc_io_peripheral with a short debounce window.
module tb_sc_io_peripheral;

  logic        clock;
  logic        reset;
  logic [9:0]  sw;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        update;
  logic        update_port;

  int n_vec = 0;
  int n_err = 0;

  sc_io_peripheral #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sw         (sw),
    .out_port0  (out_port0),
    .out_port1  (out_port1),
    .in_port0   (in_port0),
    .in_port1   (in_port1),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5),
    .update     (update),
    .update_port(update_port)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Wait (bounded) for an update pulse for the given port.
  task automatic wait_port(input logic p);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clock);
      #1;
      if (update && update_port == p) found = 1'b1;
    end
    check("update_seen", 32'(found), 32'd1);
  endtask

  // Second write of a port is guaranteed to reflect the current value.
  task automatic show(input logic p);
    wait_port(p);
    wait_port(p);
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_hex0"}, 32'(hex0), 32'h7F);
    check({tag, "_hex1"}, 32'(hex1), 32'h7F);
    check({tag, "_hex2"}, 32'(hex2), 32'h7F);
    check({tag, "_hex3"}, 32'(hex3), 32'h7F);
    check({tag, "_hex4"}, 32'(hex4), 32'h7F);
    check({tag, "_hex5"}, 32'(hex5), 32'h7F);
  endtask

  initial begin
    int n;
    logic seen;

    reset     = 1'b1;
    sw        = '0;
    out_port0 = '0;
    out_port1 = '0;

    // Reset state
    tick(2);
    check_blank("rst");
    check("rst_in_port0", in_port0, 32'h0);
    check("rst_in_port1", in_port1, 32'h0);
    check("rst_update", 32'(update), 32'h0);
    reset = 1'b0;

    // Debounce latency: switches set just after edge t, visible at edge t+7
    tick(1);
    sw = 10'h3FF;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check("db_early_in_port0", in_port0, 32'h0);
    end
    tick(1);
    check("db_in_port0", in_port0, 32'h1F);
    check("db_in_port1", in_port1, 32'h1F);

    sw = '0;
    tick(12);
    check("db_release", in_port0, 32'h0);

    // Glitch rejection: sw[0] high for 3 cycles, sw[9] held
    sw = 10'h201;
    tick(3);
    sw = 10'h200;
    tick(15);
    check("glitch_in_port0", in_port0, 32'h0);
    check("glitch_in_port1", in_port1, 32'h10);

    // Decimal display of 123 on port 0
    out_port0 = 32'd123;
    show(1'b0);
    check("p0_123_port", 32'(update_port), 32'h0);
    check("p0_123_hex5", 32'(hex5), 32'h79);
    check("p0_123_hex4", 32'(hex4), 32'h24);
    check("p0_123_hex3", 32'(hex3), 32'h30);

    // Blanking
    out_port0 = 32'd5;
    show(1'b0);
    check("p0_5_hex5", 32'(hex5), 32'h7F);
    check("p0_5_hex4", 32'(hex4), 32'h7F);
    check("p0_5_hex3", 32'(hex3), 32'h12);

    out_port1 = 32'd0;
    show(1'b1);
    check("p1_0_hex2", 32'(hex2), 32'h7F);
    check("p1_0_hex1", 32'(hex1), 32'h7F);
    check("p1_0_hex0", 32'(hex0), 32'h40);
    check("p1_0_hold_hex3", 32'(hex3), 32'h12);

    out_port1 = 32'd70;
    show(1'b1);
    check("p1_70_hex2", 32'(hex2), 32'h7F);
    check("p1_70_hex1", 32'(hex1), 32'h78);
    check("p1_70_hex0", 32'(hex0), 32'h40);

    // Clipping
    out_port1 = 32'd2000;
    show(1'b1);
    check("p1_2000_hex2", 32'(hex2), 32'h10);
    check("p1_2000_hex1", 32'(hex1), 32'h10);
    check("p1_2000_hex0", 32'(hex0), 32'h10);

    out_port1 = 32'h8000_0000;
    show(1'b1);
    check("p1_big_hex2", 32'(hex2), 32'h10);
    check("p1_big_hex1", 32'(hex1), 32'h10);
    check("p1_big_hex0", 32'(hex0), 32'h10);
    check("p0_hold_hex3", 32'(hex3), 32'h12);

    // Cadence: 12 cycles between pulses, ports alternate
    wait_port(1'b0);
    tick(1);
    check("pulse_width", 32'(update), 32'h0);
    n = 1;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick(1);
      n++;
      if (update) seen = 1'b1;
    end
    check("cadence_gap_a", 32'(n), 32'd12);
    check("cadence_port_a", 32'(update_port), 32'h1);
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick(1);
      n++;
      if (update) seen = 1'b1;
    end
    check("cadence_gap_b", 32'(n), 32'd12);
    check("cadence_port_b", 32'(update_port), 32'h0);

    // Reset during conversion
    tick(4);
    reset = 1'b1;
    tick(1);
    check_blank("midrst");
    check("midrst_update", 32'(update), 32'h0);
    check("midrst_in_port1", in_port1, 32'h0);
    reset = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick(1);
      n++;
      if (update) seen = 1'b1;
    end
    check("post_rst_gap", 32'(n), 32'd12);
    check("post_rst_port", 32'(update_port), 32'h0);
    check("post_rst_hex3", 32'(hex3), 32'h12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
